// File: rtl/mtr_pwm_pkg.sv
// Shared types, widths and helpers for the dual H-bridge PWM driver.
package mtr_pwm_pkg;

  localparam int unsigned PWM_W = 10;
  localparam int unsigned CMD_W = 11;

  typedef enum logic [1:0] {
    COAST = 2'd0,
    FWD   = 2'd1,
    REV   = 2'd2,
    DEAD  = 2'd3
  } mtr_st_t;

  localparam logic [PWM_W-1:0] CNT_ZERO = {PWM_W{1'b0}};
  localparam logic [PWM_W-1:0] CNT_ONE  = {{(PWM_W-1){1'b0}}, 1'b1};
  localparam logic [PWM_W-1:0] CNT_MAX  = {PWM_W{1'b1}};

  // Magnitude of a two's-complement command; the most negative code saturates to full scale.
  function automatic logic [PWM_W-1:0] sat_mag(input logic [CMD_W-1:0] cmd);
    logic [CMD_W-1:0] abs_v;
    abs_v = cmd[CMD_W-1] ? (~cmd + {{(CMD_W-1){1'b0}}, 1'b1}) : cmd;
    return abs_v[CMD_W-1] ? CNT_MAX : abs_v[PWM_W-1:0];
  endfunction

endpackage

// File: rtl/mtr_pwm_chan.sv
// One motor channel: period-sampled command, direction FSM with reversal
// dead-time, and registered fwd/rev drive compared against the shared counter.
module mtr_pwm_chan
  import mtr_pwm_pkg::*;
#(
  parameter int unsigned DEAD_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] cnt,
  input  logic             smp,
  input  logic             go,
  input  logic [CMD_W-1:0] cmd,
  output logic             fwd,
  output logic             rev
);

  localparam logic [PWM_W-1:0] DEAD_LD = PWM_W'(DEAD_CYC);

  mtr_st_t          st_r, st_nxt_s, tgt_r, tgt_nxt_s;
  logic [PWM_W-1:0] tmr_r, tmr_nxt_s;
  logic [PWM_W-1:0] mag_r, mag_s;
  logic             sgn_s;
  logic             fwd_r, rev_r;

  assign sgn_s = cmd[CMD_W-1];
  assign mag_s = sat_mag(cmd);

  // Next-state: go low forces COAST and wins over sample and timer expiry.
  always_comb begin
    st_nxt_s  = st_r;
    tgt_nxt_s = tgt_r;
    tmr_nxt_s = tmr_r;
    if (!go) begin
      st_nxt_s  = COAST;
      tmr_nxt_s = CNT_ZERO;
    end else begin
      case (st_r)
        COAST: begin
          if (smp && (mag_s != CNT_ZERO)) begin
            st_nxt_s = sgn_s ? REV : FWD;
          end else begin
            st_nxt_s = COAST;
          end
        end
        FWD, REV: begin
          if (!smp) begin
            st_nxt_s = st_r;
          end else if (mag_s == CNT_ZERO) begin
            st_nxt_s = COAST;
          end else if (sgn_s == (st_r == FWD)) begin
            // Direction flip: park both legs low before driving the other way.
            st_nxt_s  = DEAD;
            tgt_nxt_s = sgn_s ? REV : FWD;
            tmr_nxt_s = DEAD_LD;
          end else begin
            st_nxt_s = st_r;
          end
        end
        DEAD: begin
          if (tmr_r <= CNT_ONE) begin
            st_nxt_s  = tgt_r;
            tmr_nxt_s = CNT_ZERO;
          end else begin
            tmr_nxt_s = tmr_r - CNT_ONE;
          end
        end
        default: begin
          st_nxt_s  = COAST;
          tmr_nxt_s = CNT_ZERO;
        end
      endcase
    end
  end

  // State, captured magnitude and drive flops; drives are cut the clock after go drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_r  <= COAST;
      tgt_r <= COAST;
      tmr_r <= CNT_ZERO;
      mag_r <= CNT_ZERO;
      fwd_r <= 1'b0;
      rev_r <= 1'b0;
    end else begin
      st_r  <= st_nxt_s;
      tgt_r <= tgt_nxt_s;
      tmr_r <= tmr_nxt_s;
      if (smp) begin
        mag_r <= mag_s;
      end
      fwd_r <= go && (st_r == FWD) && (cnt < mag_r);
      rev_r <= go && (st_r == REV) && (cnt < mag_r);
    end
  end

  assign fwd = fwd_r;
  assign rev = rev_r;

endmodule

// File: rtl/mtr_pwm_drv.sv
// Dual-motor H-bridge PWM driver: shared free-running period counter and
// sample strobe feeding one channel per motor.
module mtr_pwm_drv
  import mtr_pwm_pkg::*;
#(
  parameter int unsigned DEAD_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [CMD_W-1:0] lft,
  input  logic [CMD_W-1:0] rht,
  output logic             fwd_lft,
  output logic             rev_lft,
  output logic             fwd_rht,
  output logic             rev_rht
);

  logic [PWM_W-1:0] cnt_r;
  logic             smp_s;

  // Period counter runs regardless of go so both channels stay phase-locked.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign smp_s = (cnt_r == CNT_MAX);

  mtr_pwm_chan #(.DEAD_CYC(DEAD_CYC)) u_lft (
    .clk (clk),
    .rst (rst),
    .cnt (cnt_r),
    .smp (smp_s),
    .go  (go),
    .cmd (lft),
    .fwd (fwd_lft),
    .rev (rev_lft)
  );

  mtr_pwm_chan #(.DEAD_CYC(DEAD_CYC)) u_rht (
    .clk (clk),
    .rst (rst),
    .cnt (cnt_r),
    .smp (smp_s),
    .go  (go),
    .cmd (rht),
    .fwd (fwd_rht),
    .rev (rev_rht)
  );

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// Self-checking bench for mtr_pwm_drv: duty table, reversal/go/reset sequences,
// and randomized stimulus against a period-level reference model.
module tb_mtr_pwm_drv;

  localparam int PERIOD = 1024;
  localparam int DEADC  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go  = 1'b0;
  logic signed [10:0] lft = 11'sd0;
  logic signed [10:0] rht = 11'sd0;
  logic fwd_lft, rev_lft, fwd_rht, rev_rht;

  int checks = 0;
  int errors = 0;

  // model: per-period direction (+1/-1/0), magnitude and blanking length
  int m_cnt = 0;
  int m_dir [2] = '{0, 0};
  int m_mag [2] = '{0, 0};
  int m_dead[2] = '{0, 0};

  // reversal gap monitor
  bit mon_en = 1'b0;
  int last_d [2] = '{0, 0};
  int low_run[2] = '{0, 0};
  int rev_seen = 0;

  typedef struct {
    int l; int r; bit g;
    int efl; int erl; int efr; int err;
  } vec_t;
  vec_t tbl[8];

  mtr_pwm_drv dut (
    .clk(clk), .rst(rst), .go(go), .lft(lft), .rht(rht),
    .fwd_lft(fwd_lft), .rev_lft(rev_lft), .fwd_rht(fwd_rht), .rev_rht(rev_rht)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    int ef[2], er[2], v, mg, nd, d;
    int got_f[2], got_r[2];
    for (int ch = 0; ch < 2; ch++) begin
      ef[ch] = (!rst && go && m_dir[ch] == 1  && m_cnt >= m_dead[ch] && m_cnt < m_mag[ch]) ? 1 : 0;
      er[ch] = (!rst && go && m_dir[ch] == -1 && m_cnt >= m_dead[ch] && m_cnt < m_mag[ch]) ? 1 : 0;
    end
    @(posedge clk);
    #1;
    got_f[0] = int'(fwd_lft); got_r[0] = int'(rev_lft);
    got_f[1] = int'(fwd_rht); got_r[1] = int'(rev_rht);
    chk("fwd_lft", got_f[0], ef[0]);
    chk("rev_lft", got_r[0], er[0]);
    chk("fwd_rht", got_f[1], ef[1]);
    chk("rev_rht", got_r[1], er[1]);
    chk("excl_lft", got_f[0] & got_r[0], 0);
    chk("excl_rht", got_f[1] & got_r[1], 0);
    if (mon_en) begin
      for (int ch = 0; ch < 2; ch++) begin
        d = got_f[ch] ? 1 : (got_r[ch] ? -1 : 0);
        if (d != 0) begin
          if (last_d[ch] != 0 && d != last_d[ch]) begin
            chk("rev_gap", (low_run[ch] >= DEADC) ? DEADC : low_run[ch], DEADC);
            rev_seen++;
          end
          last_d[ch] = d;
          low_run[ch] = 0;
        end else begin
          low_run[ch]++;
        end
      end
    end
    if (rst) begin
      m_cnt = 0;
      for (int ch = 0; ch < 2; ch++) begin
        m_dir[ch] = 0; m_mag[ch] = 0; m_dead[ch] = 0;
      end
    end else begin
      if (!go) begin
        m_dir[0] = 0;
        m_dir[1] = 0;
      end else if (m_cnt == PERIOD - 1) begin
        for (int ch = 0; ch < 2; ch++) begin
          v  = (ch == 0) ? int'(lft) : int'(rht);
          mg = (v < 0) ? -v : v;
          if (mg > PERIOD - 1) mg = PERIOD - 1;
          m_mag[ch] = mg;
          if (mg == 0) begin
            m_dir[ch] = 0; m_dead[ch] = 0;
          end else begin
            nd = (v < 0) ? -1 : 1;
            m_dead[ch] = (m_dir[ch] != 0 && m_dir[ch] != nd) ? DEADC : 0;
            m_dir[ch]  = nd;
          end
        end
      end
      m_cnt = (m_cnt + 1) % PERIOD;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_cnt(input int c);
    while (m_cnt != c) tick();
  endtask

  function automatic logic signed [10:0] rnd_cmd();
    case ($urandom_range(0, 5))
      0: return 11'sh400;
      1: return 11'sd0;
      2: return 11'sd1023;
      default: return 11'($urandom_range(0, 2047));
    endcase
  endfunction

  initial begin
    int nf, nr, nfr, nrr, lead, first_hi;

    tbl[0] = '{256,    0, 1'b1,  256,    0,    0,    0};
    tbl[1] = '{0,   -512, 1'b1,    0,    0,    0,  512};
    tbl[2] = '{0,  -1024, 1'b1,    0,    0,    0, 1023};
    tbl[3] = '{1023,   1, 1'b1, 1023,    0,    1,    0};
    tbl[4] = '{-1,  1023, 1'b1,    0,    1, 1023,    0};
    tbl[5] = '{500, -500, 1'b0,    0,    0,    0,    0};
    tbl[6] = '{0,      0, 1'b1,    0,    0,    0,    0};
    tbl[7] = '{-1023, 700, 1'b1,   0, 1023,  700,    0};

    // reset state
    rst = 1'b1; go = 1'b0;
    run(3);
    chk("reset_out", int'({fwd_lft, rev_lft, fwd_rht, rev_rht}), 0);
    rst = 1'b0;

    // steady-state duty table
    for (int i = 0; i < 8; i++) begin
      lft = 11'(tbl[i].l); rht = 11'(tbl[i].r); go = tbl[i].g;
      run(2100);
      nf = 0; nr = 0; nfr = 0; nrr = 0;
      for (int k = 0; k < PERIOD; k++) begin
        tick();
        nf += int'(fwd_lft); nr += int'(rev_lft);
        nfr += int'(fwd_rht); nrr += int'(rev_rht);
      end
      chk($sformatf("duty_fl_%0d", i), nf, tbl[i].efl);
      chk($sformatf("duty_rl_%0d", i), nr, tbl[i].erl);
      chk($sformatf("duty_fr_%0d", i), nfr, tbl[i].efr);
      chk($sformatf("duty_rr_%0d", i), nrr, tbl[i].err);
    end

    // reversal 256 -> -256 at cnt 300
    lft = 11'sd256; rht = 11'sd0; go = 1'b1;
    run(2100);
    wait_cnt(300);
    lft = -11'sd256;
    wait_cnt(0);
    nf = 0; nr = 0; lead = -1;
    for (int k = 0; k < PERIOD; k++) begin
      tick();
      nf += int'(fwd_lft); nr += int'(rev_lft);
      if (lead < 0 && (fwd_lft || rev_lft)) lead = k;
    end
    chk("rev1_fwd", nf, 0);
    chk("rev1_lead", lead, DEADC);
    chk("rev1_rev", nr, 192);
    nr = 0;
    for (int k = 0; k < PERIOD; k++) begin
      tick();
      nr += int'(rev_lft);
    end
    chk("rev2_rev", nr, 256);

    // sign toggle every period
    lft = 11'sd300;
    run(2100);
    wait_cnt(0);
    mon_en = 1'b1;
    for (int p = 0; p < 8; p++) begin
      wait_cnt(1000);
      lft = -lft;
      tick();
    end
    wait_cnt(1000);
    mon_en = 1'b0;
    chk("rev_count", rev_seen, 8);

    // go falls mid-pulse, resumes only after the wrap
    lft = 11'sd512;
    run(2100);
    wait_cnt(100);
    go = 1'b0;
    tick();
    chk("go_fall", int'(fwd_lft), 0);
    wait_cnt(400);
    go = 1'b1;
    nf = 0;
    while (m_cnt != 0) begin
      tick();
      nf += int'(fwd_lft);
    end
    chk("go_hold", nf, 0);
    nf = 0;
    for (int k = 0; k < PERIOD; k++) begin
      tick();
      nf += int'(fwd_lft);
    end
    chk("go_resume", nf, 512);

    // reset mid-DEAD, then counter restart seen through first drive
    wait_cnt(500);
    lft = -11'sd512;
    wait_cnt(30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_dead", int'({fwd_lft, rev_lft, fwd_rht, rev_rht}), 0);
    first_hi = -1;
    for (int k = 1; k <= 3000 && first_hi < 0; k++) begin
      tick();
      if (rev_lft) first_hi = k;
    end
    chk("rst_restart", first_hi, PERIOD + 1);

    // reset mid-pulse
    wait_cnt(200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_pulse", int'({fwd_lft, rev_lft, fwd_rht, rev_rht}), 0);

    // randomized stimulus against the model
    for (int k = 0; k < 12000; k++) begin
      if ($urandom_range(0, 299) == 0) lft = rnd_cmd();
      if ($urandom_range(0, 299) == 0) rht = rnd_cmd();
      if ($urandom_range(0, 1999) == 0) go = ~go;
      rst = ($urandom_range(0, 4999) == 0);
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
